pulse_width_encoder: RTL and testbench

PULSE_WIDTH_ENCODER -- requirements
Module: pulse_width_encoder

---
 rtl/pulse_width_encoder.sv | 109 ++++++++++
 tb/tb_pulse_width_encoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_width_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pulse_width_encoder                                                      |
// | Three-stage intensity-to-pulse-width lookup with phase alignment and     |
// | per-burst transducer indexing.                                           |
// | Option: PULSE_WIDTH_ENCODER_FULL_SCALE_BYPASS_EN forces width 256 for    |
// | full-scale intensity.                                                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pulse_width_encoder #(
  parameter int DEPTH = 249
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DIN_VALID,
  input  logic [15:0] INTENSITY_IN,
  input  logic [7:0]  PHASE_IN,
  output logic [15:0] TABLE_ADDR,
  input  logic [8:0]  TABLE_DATA,
  output logic [8:0]  PULSE_WIDTH_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic        DOUT_VALID,
  output logic [7:0]  DOUT_IDX,
  output logic        DONE
);

  localparam logic [7:0] c_last_idx = 8'(DEPTH - 1);

  logic       r_valid1;
  logic [7:0] r_phase1;
  logic       r_valid2;
  logic [7:0] r_phase2;
  logic [8:0] r_data2;
  logic [7:0] r_idx;
  logic [8:0] w_pw;

`ifdef PULSE_WIDTH_ENCODER_FULL_SCALE_BYPASS_EN
  localparam logic [15:0] c_full_scale = 16'd65025;
  logic r_full1;
  logic r_full2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_full1 <= 1'b0;
      r_full2 <= 1'b0;
    end else begin
      if (DIN_VALID) r_full1 <= (INTENSITY_IN >= c_full_scale);
      if (r_valid1)  r_full2 <= r_full1;
    end
  end

  assign w_pw = r_full2 ? 9'd256 : r_data2;
`else
  assign w_pw = r_data2;
`endif

  // Stage 1: the registered intensity is the table address; it only moves on valid input.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid1   <= 1'b0;
      r_phase1   <= 8'd0;
      TABLE_ADDR <= 16'd0;
    end else begin
      r_valid1 <= DIN_VALID;
      if (DIN_VALID) begin
        TABLE_ADDR <= INTENSITY_IN;
        r_phase1   <= PHASE_IN;
      end
    end
  end

  // Stage 2: table read data returns one cycle after the address.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_valid2 <= 1'b0;
      r_phase2 <= 8'd0;
      r_data2  <= 9'd0;
    end else begin
      r_valid2 <= r_valid1;
      if (r_valid1) begin
        r_data2  <= TABLE_DATA;
        r_phase2 <= r_phase1;
      end
    end
  end

  // Stage 3: outputs hold their last values between valid samples.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DOUT_VALID      <= 1'b0;
      DONE            <= 1'b0;
      PULSE_WIDTH_OUT <= 9'd0;
      PHASE_OUT       <= 8'd0;
      DOUT_IDX        <= 8'd0;
      r_idx           <= 8'd0;
    end else begin
      DOUT_VALID <= r_valid2;
      DONE       <= r_valid2 && (r_idx == c_last_idx);
      if (r_valid2) begin
        PULSE_WIDTH_OUT <= w_pw;
        PHASE_OUT       <= r_phase2;
        DOUT_IDX        <= r_idx;
        r_idx           <= (r_idx == c_last_idx) ? 8'd0 : r_idx + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pulse_width_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pulse_width_encoder                                                   |
// | Self-checking bench for pulse_width_encoder with a behavioural model.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pulse_width_encoder;
  localparam int DEPTH = 249;
  localparam int MAXN  = 800;
`ifdef PULSE_WIDTH_ENCODER_FULL_SCALE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        DIN_VALID;
  logic [15:0] INTENSITY_IN;
  logic [7:0]  PHASE_IN;
  logic [15:0] TABLE_ADDR;
  logic [8:0]  TABLE_DATA;
  logic [8:0]  PULSE_WIDTH_OUT;
  logic [7:0]  PHASE_OUT;
  logic        DOUT_VALID;
  logic [7:0]  DOUT_IDX;
  logic        DONE;
  bit          force17 = 1'b0;

  always #5 CLK = ~CLK;

  // Table stand-in: data = addr[15:7], optionally overridden to a constant 17.
  assign TABLE_DATA = force17 ? 9'd17 : TABLE_ADDR[15:7];

  pulse_width_encoder #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN_VALID(DIN_VALID), .INTENSITY_IN(INTENSITY_IN),
    .PHASE_IN(PHASE_IN), .TABLE_ADDR(TABLE_ADDR), .TABLE_DATA(TABLE_DATA),
    .PULSE_WIDTH_OUT(PULSE_WIDTH_OUT), .PHASE_OUT(PHASE_OUT), .DOUT_VALID(DOUT_VALID),
    .DOUT_IDX(DOUT_IDX), .DONE(DONE)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  bit          s_v [MAXN];
  bit          s_r [MAXN];
  logic [15:0] s_i [MAXN];
  logic [7:0]  s_p [MAXN];
  logic [26:0] obs [MAXN+3];
  logic [26:0] expv[MAXN+3];
  logic [15:0] obs_ta[MAXN+3];
  int          n_cur;

  int          m_idx = 0;
  logic [8:0]  m_pw = '0;
  logic [7:0]  m_ph = '0;
  logic [7:0]  m_ix = '0;

  function automatic logic [8:0] ref_pw(logic [15:0] x);
    if (BYPASS && x >= 16'd65025) return 9'd256;
    if (force17) return 9'd17;
    return 9'(x / 128);
  endfunction

  function automatic bit rr(int k);
    return (k < 0 || k >= n_cur) ? 1'b1 : s_r[k];
  endfunction

  task automatic clear_stim(int n);
    n_cur = n;
    for (int k = 0; k < MAXN; k++) begin
      s_v[k] = 1'b0; s_r[k] = 1'b1;
      s_i[k] = 16'($urandom_range(0, 65535)); s_p[k] = 8'($urandom_range(0, 255));
    end
  endtask

  // Reference: a sample at cycle k emerges at cycle k+3 unless reset intervenes; idx counts outputs.
  task automatic build_expected();
    for (int j = 0; j < n_cur + 3; j++) begin
      if (!rr(j - 1)) begin
        m_idx = 0; m_pw = '0; m_ph = '0; m_ix = '0;
        expv[j] = '0;
      end else if (j >= 3 && s_v[j-3] && rr(j-3) && rr(j-2) && rr(j-1)) begin
        m_pw = ref_pw(s_i[j-3]); m_ph = s_p[j-3]; m_ix = 8'(m_idx);
        expv[j] = {1'b1, (m_idx == DEPTH - 1), m_pw, m_ph, m_ix};
        m_idx = (m_idx + 1) % DEPTH;
      end else begin
        expv[j] = {2'b00, m_pw, m_ph, m_ix};
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < n_cur + 3; k++) begin
      @(negedge CLK);
      obs[k]    = {DOUT_VALID, DONE, PULSE_WIDTH_OUT, PHASE_OUT, DOUT_IDX};
      obs_ta[k] = TABLE_ADDR;
      if (k < n_cur) begin
        RST_N = s_r[k]; DIN_VALID = s_v[k]; INTENSITY_IN = s_i[k]; PHASE_IN = s_p[k];
      end else begin
        RST_N = 1'b1; DIN_VALID = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; DIN_VALID = 1'b0; INTENSITY_IN = 16'hFFFF; PHASE_IN = 8'hAA;
    repeat (3) @(negedge CLK);
    total_cnt++; if ({DOUT_VALID, DONE} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {DOUT_VALID, DONE}); else pass_cnt++;
    total_cnt++; if (PULSE_WIDTH_OUT !== 9'd0) $display("FAIL reset_pw: got %0d want 0", PULSE_WIDTH_OUT); else pass_cnt++;
    total_cnt++; if (PHASE_OUT !== 8'd0) $display("FAIL reset_phase: got %0d want 0", PHASE_OUT); else pass_cnt++;
    total_cnt++; if (DOUT_IDX !== 8'd0) $display("FAIL reset_idx: got %0d want 0", DOUT_IDX); else pass_cnt++;
    total_cnt++; if (TABLE_ADDR !== 16'd0) $display("FAIL reset_addr: got %0h want 0", TABLE_ADDR); else pass_cnt++;
    RST_N = 1'b1;
  endtask

  task automatic test_single_burst();
    int dones = 0;
    clear_stim(DEPTH);
    for (int k = 0; k < DEPTH; k++) begin s_v[k] = 1'b1; s_i[k] = 16'h8000; s_p[k] = 8'(k); end
    build_expected(); drive();
    for (int j = 0; j < n_cur + 3; j++) begin
      total_cnt++;
      if (obs[j] !== expv[j]) $display("FAIL single[%0d]: got %h want %h", j, obs[j], expv[j]); else pass_cnt++;
      if (obs[j][25]) dones++;
    end
    total_cnt++; if (obs[3] !== {2'b10, 9'd256, 8'd0, 8'd0}) $display("FAIL single_first: got %h want %h", obs[3], {2'b10, 9'd256, 16'd0}); else pass_cnt++;
    total_cnt++; if (obs[DEPTH+2][25:0] !== {1'b1, 9'd256, 8'd248, 8'd248}) $display("FAIL single_last: got %h", obs[DEPTH+2]); else pass_cnt++;
    total_cnt++; if (dones != 1) $display("FAIL single_done_count: got %0d want 1", dones); else pass_cnt++;
  endtask

  task automatic test_gap();
    clear_stim(DEPTH + 5);
    for (int k = 0; k < DEPTH + 5; k++) s_v[k] = (k <= 100 || k >= 106);
    build_expected(); drive();
    for (int j = 0; j < n_cur + 3; j++) begin
      total_cnt++;
      if (obs[j] !== expv[j]) $display("FAIL gap[%0d]: got %h want %h", j, obs[j], expv[j]); else pass_cnt++;
    end
    for (int j = 102; j <= 106; j++) begin
      total_cnt++;
      if (obs_ta[j] !== s_i[100]) $display("FAIL gap_addr_hold[%0d]: got %h want %h", j, obs_ta[j], s_i[100]); else pass_cnt++;
    end
    total_cnt++; if (obs[109][26] !== 1'b1 || obs[109][7:0] !== 8'd101) $display("FAIL gap_resume: got %h want idx 101", obs[109]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int valids = 0, dones = 0;
    clear_stim(2 * DEPTH);
    for (int k = 0; k < 2 * DEPTH; k++) s_v[k] = 1'b1;
    build_expected(); drive();
    for (int j = 0; j < n_cur + 3; j++) begin
      total_cnt++;
      if (obs[j] !== expv[j]) $display("FAIL b2b[%0d]: got %h want %h", j, obs[j], expv[j]); else pass_cnt++;
      if (obs[j][26]) valids++;
      if (obs[j][25]) dones++;
    end
    total_cnt++; if (valids != 2 * DEPTH) $display("FAIL b2b_valid_count: got %0d want %0d", valids, 2 * DEPTH); else pass_cnt++;
    total_cnt++; if (dones != 2) $display("FAIL b2b_done_count: got %0d want 2", dones); else pass_cnt++;
    total_cnt++; if (obs[DEPTH+3][7:0] !== 8'd0 || obs[DEPTH+2][7:0] !== 8'd248) $display("FAIL b2b_wrap: got %0d,%0d want 248,0", obs[DEPTH+2][7:0], obs[DEPTH+3][7:0]); else pass_cnt++;
  endtask

  // Upstream silencer: each transducer slews toward a random target by at most STEP per burst.
  task automatic test_silencer_chain();
    int cur[DEPTH], tgt[DEPTH], ph[DEPTH];
    localparam int STEP = 8192;
    for (int t = 0; t < DEPTH; t++) begin cur[t] = 0; tgt[t] = $urandom_range(0, 65025); ph[t] = $urandom_range(0, 255); end
    clear_stim(3 * DEPTH);
    for (int b = 0; b < 3; b++)
      for (int t = 0; t < DEPTH; t++) begin
        if (tgt[t] - cur[t] > STEP) cur[t] += STEP;
        else if (cur[t] - tgt[t] > STEP) cur[t] -= STEP;
        else cur[t] = tgt[t];
        s_v[b*DEPTH+t] = 1'b1; s_i[b*DEPTH+t] = 16'(cur[t]); s_p[b*DEPTH+t] = 8'(ph[t]);
      end
    build_expected(); drive();
    for (int j = 0; j < n_cur + 3; j++) begin
      total_cnt++;
      if (obs[j] !== expv[j]) $display("FAIL silencer[%0d]: got %h want %h", j, obs[j], expv[j]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_burst();
    int late = 0;
    clear_stim(57);
    for (int k = 0; k < 52; k++) s_v[k] = 1'b1;
    s_r[50] = 1'b0; s_r[51] = 1'b0; s_v[56] = 1'b1;
    build_expected(); drive();
    for (int j = 0; j < n_cur + 3; j++) begin
      total_cnt++;
      if (obs[j] !== expv[j]) $display("FAIL rst_mid[%0d]: got %h want %h", j, obs[j], expv[j]); else pass_cnt++;
      if (j >= 51 && j <= 58 && obs[j][26]) late++;
    end
    total_cnt++; if (late != 0) $display("FAIL rst_mid_stale: got %0d stale outputs want 0", late); else pass_cnt++;
    total_cnt++; if (obs[59][26] !== 1'b1 || obs[59][7:0] !== 8'd0) $display("FAIL rst_mid_restart: got %h want valid idx 0", obs[59]); else pass_cnt++;
  endtask

  task automatic test_full_scale();
    logic [8:0] want;
    force17 = 1'b1;
    clear_stim(5);
    for (int k = 0; k < 5; k++) s_v[k] = 1'b1;
    s_i[0] = 16'd65025; s_i[1] = 16'd65535; s_i[2] = 16'd65024; s_i[3] = 16'h8000;
    build_expected(); drive();
    for (int j = 0; j < n_cur + 3; j++) begin
      total_cnt++;
      if (obs[j] !== expv[j]) $display("FAIL full_scale[%0d]: got %h want %h", j, obs[j], expv[j]); else pass_cnt++;
    end
    want = BYPASS ? 9'd256 : 9'd17;
    total_cnt++; if (obs[3][24:16] !== want) $display("FAIL full_scale_65025: got %0d want %0d", obs[3][24:16], want); else pass_cnt++;
    total_cnt++; if (obs[5][24:16] !== 9'd17) $display("FAIL full_scale_65024: got %0d want 17", obs[5][24:16]); else pass_cnt++;
    force17 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_gap();
    test_back_to_back();
    test_silencer_chain();
    test_reset_mid_burst();
    test_full_scale();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
